load_cell_cond: RTL and testbench

- Conditions the left/right load-cell readings from the A2D interface into the rider-presence and rider-balance flags consumed by the steer-enable state machine.
- Also owns the 1.3 s settle timer, which that state machine clears and monitors.
- Sits between the A2D interface and the steer-enable SM.
- Block-averages samples and applies hysteresis and ratio comparisons.

---
 rtl/load_cell_pkg.sv | 20 ++
 rtl/load_cell_cond_settle_tmr.sv | 38 +++
 rtl/load_cell_cond.sv | 118 +++++++++++
 tb/tb_load_cell_cond.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/load_cell_pkg.sv
// Shared constants for the load-cell conditioning block: default rider
// thresholds, settle-timer widths and averaging geometry.
package load_cell_pkg;

  // Nominal rider-weight threshold on the left+right sum, and the
  // half-width of the hysteresis band around it.
  localparam logic [11:0] MIN_RIDER_WEIGHT_DEF = 12'h200;
  localparam logic [11:0] HYSTERESIS_DEF       = 12'h040;

  // Settle timer: full-length width for hardware, short width for simulation.
  localparam int TMR_W     = 26;
  localparam int TMR_W_SIM = 15;

  // Block averaging over a power-of-two number of samples.
  localparam int LD_W        = 12;
  localparam int AVG_SAMPLES = 4;
  localparam int AVG_SHIFT   = $clog2(AVG_SAMPLES);
  localparam int ACC_W       = LD_W + AVG_SHIFT;

endpackage : load_cell_pkg

// File: rtl/load_cell_cond_settle_tmr.sv
// Saturating settle timer. Counts every cycle from a synchronous clear and
// reports full at its terminal count; stays full until cleared again.
module settle_tmr
  import load_cell_pkg::*;
#(
  parameter int FAST_SIM = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_tmr,
  output logic tmr_full
);

  logic [TMR_W-1:0] cnt;

  // Terminal count: short compare in simulation, full width in hardware.
  generate
    if (FAST_SIM != 0) begin : g_fast
      assign tmr_full = &cnt[TMR_W_SIM-1:0];
    end else begin : g_full
      assign tmr_full = &cnt;
    end
  endgenerate

  // Count up; clear wins, and the count freezes once full so the flag holds.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking (<=) in clocked blocks so every register samples
    // pre-edge values regardless of statement order across always blocks.
    if (rst) begin
      cnt <= '0;
    end else if (clr_tmr) begin
      cnt <= '0;
    end else if (!tmr_full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : settle_tmr

// File: rtl/load_cell_cond.sv
// Load-cell conditioning: block-averages left/right samples, then derives
// rider-presence (with hysteresis) and rider-balance flags for the
// steer-enable state machine. Also hosts the settle timer it monitors.
module load_cell_cond
  import load_cell_pkg::*;
#(
  parameter int          FAST_SIM         = 0,
  parameter logic [11:0] MIN_RIDER_WEIGHT = MIN_RIDER_WEIGHT_DEF,
  parameter logic [11:0] HYSTERESIS       = HYSTERESIS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  input  logic            clr_tmr,
  output logic [LD_W-1:0] lft_avg,
  output logic [LD_W-1:0] rght_avg,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16,
  output logic            tmr_full,
  output logic            flags_vld
);

  // Hysteresis thresholds on the 13-bit sum.
  localparam logic [LD_W:0] SUM_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [LD_W:0] SUM_LO = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};
  localparam logic [AVG_SHIFT-1:0] LAST_SAMPLE = AVG_SHIFT'(AVG_SAMPLES - 1);

  logic [ACC_W-1:0]     lft_acc, rght_acc;
  logic [ACC_W-1:0]     lft_acc_nxt, rght_acc_nxt;
  logic [AVG_SHIFT-1:0] samp_cnt;
  logic                 avg_vld;

  logic [LD_W:0]   sum;
  logic [LD_W-1:0] diff;
  logic [ACC_W-1:0] diff_x4, sum_w14;
  logic [LD_W+4:0]  diff_x16, sum_x15;

  // Running sums including the sample presented this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (defaults
    // first) so no latch is inferred.
    lft_acc_nxt  = lft_acc + ACC_W'(lft_ld);
    rght_acc_nxt = rght_acc + ACC_W'(rght_ld);
  end

  // Block accumulation: the final sample of each block is folded in and the
  // block average is published; the accumulators restart from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_acc  <= '0;
      rght_acc <= '0;
      samp_cnt <= '0;
      lft_avg  <= '0;
      rght_avg <= '0;
      avg_vld  <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (ld_vld) begin
        if (samp_cnt == LAST_SAMPLE) begin
          lft_avg  <= lft_acc_nxt[ACC_W-1:AVG_SHIFT];
          rght_avg <= rght_acc_nxt[ACC_W-1:AVG_SHIFT];
          avg_vld  <= 1'b1;
          lft_acc  <= '0;
          rght_acc <= '0;
          samp_cnt <= '0;
        end else begin
          lft_acc  <= lft_acc_nxt;
          rght_acc <= rght_acc_nxt;
          samp_cnt <= samp_cnt + 1'b1;
        end
      end
    end
  end

  // Sum/difference of the averages and the division-free ratio operands:
  // diff > sum/4  <=> 4*diff > sum;  diff > 15/16*sum <=> 16*diff > 15*sum.
  always_comb begin
    sum      = {1'b0, lft_avg} + {1'b0, rght_avg};
    diff     = (lft_avg >= rght_avg) ? (lft_avg - rght_avg) : (rght_avg - lft_avg);
    diff_x4  = {diff, 2'b00};
    sum_w14  = {1'b0, sum};
    diff_x16 = {1'b0, diff, 4'b0000};
    sum_x15  = {sum, 4'b0000} - {4'b0000, sum};
  end

  // Flag stage: refresh all flags one cycle after a new average, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_gt_min    <= 1'b0;
      sum_lt_min    <= 1'b1;
      diff_gt_1_4   <= 1'b0;
      diff_gt_15_16 <= 1'b0;
      flags_vld     <= 1'b0;
    end else begin
      flags_vld <= avg_vld;
      if (avg_vld) begin
        sum_gt_min    <= (sum > SUM_HI);
        sum_lt_min    <= (sum < SUM_LO);
        diff_gt_1_4   <= (diff_x4 > sum_w14);
        diff_gt_15_16 <= (diff_x16 > sum_x15);
      end
    end
  end

  settle_tmr #(
    .FAST_SIM (FAST_SIM)
  ) u_settle_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr_tmr  (clr_tmr),
    .tmr_full (tmr_full)
  );

endmodule : load_cell_cond

// File: tb/tb_load_cell_cond.sv
// Directed bench for load_cell_cond: averaging latency, hysteresis band,
// balance ratios, settle timer (short mode) and mid-block reset.
module tb_load_cell_cond;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft_ld, rght_ld;
  logic        ld_vld, clr_tmr;
  logic [11:0] lft_avg, rght_avg;
  logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;
  logic        tmr_full, flags_vld;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  load_cell_cond #(
    .FAST_SIM (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .ld_vld        (ld_vld),
    .clr_tmr       (clr_tmr),
    .lft_avg       (lft_avg),
    .rght_avg      (rght_avg),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_1_4   (diff_gt_1_4),
    .diff_gt_15_16 (diff_gt_15_16),
    .tmr_full      (tmr_full),
    .flags_vld     (flags_vld)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present samples on consecutive cycles; returns 1 cycle after the last edge.
  task automatic feed(input int n, input logic [11:0] l, input logic [11:0] r);
    for (int i = 0; i < n; i++) begin
      lft_ld  = l;
      rght_ld = r;
      ld_vld  = 1'b1;
      @(posedge clk); #1;
    end
    ld_vld = 1'b0;
  endtask

  // One averaging block, with averages checked at N+1 and flags at N+2.
  task automatic block(input string tag, input logic [11:0] l, input logic [11:0] r,
                       input logic [11:0] exp_l, input logic [11:0] exp_r,
                       input logic [3:0] exp_flags);
    feed(4, l, r);
    check({tag, "_lft_avg"}, 32'(lft_avg), 32'(exp_l));
    check({tag, "_rght_avg"}, 32'(rght_avg), 32'(exp_r));
    check({tag, "_vld_n1"}, 32'(flags_vld), 32'd0);
    @(posedge clk); #1;
    check({tag, "_vld_n2"}, 32'(flags_vld), 32'd1);
    check({tag, "_flags"},
          32'({sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}), 32'(exp_flags));
    @(posedge clk); #1;
    check({tag, "_vld_n3"}, 32'(flags_vld), 32'd0);
    check({tag, "_flags_hold"},
          32'({sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}), 32'(exp_flags));
  endtask

  initial begin
    rst     = 1'b1;
    lft_ld  = '0;
    rght_ld = '0;
    ld_vld  = 1'b0;
    clr_tmr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state; flags packed as {gt, lt, d14, d1516}.
    check("rst_flags", 32'({sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}), 32'b0100);
    check("rst_lft_avg", 32'(lft_avg), 32'd0);
    check("rst_rght_avg", 32'(rght_avg), 32'd0);
    check("rst_tmr_full", 32'(tmr_full), 32'd0);
    check("rst_flags_vld", 32'(flags_vld), 32'd0);

    // Balanced rider above the band: sum 0x2A0 > 0x240.
    block("above", 12'h150, 12'h150, 12'h150, 12'h150, 4'b1000);
    // Sum exactly 0x200: inside the band.
    block("band", 12'h100, 12'h100, 12'h100, 12'h100, 4'b0000);
    // Sum 0x1BE < 0x1C0: below the band.
    block("below", 12'h0DF, 12'h0DF, 12'h0DF, 12'h0DF, 4'b0100);
    // diff 384, sum 640: 1536 > 640, 6144 <= 9600.
    block("imb1", 12'h200, 12'h080, 12'h200, 12'h080, 4'b1010);
    // diff 632, sum 648: 2528 > 648, 10112 > 9720.
    block("imb2", 12'h280, 12'h008, 12'h280, 12'h008, 4'b1011);
    // Unequal samples averaged: left 0x100,0x104,0x108,0x10C -> 0x106 is
    // not generated here; instead check truncation with 0x101 x3 + 0x102.
    feed(3, 12'h101, 12'h003);
    feed(1, 12'h102, 12'h002);
    check("trunc_lft_avg", 32'(lft_avg), 32'h101);   // 0x405 >> 2
    check("trunc_rght_avg", 32'(rght_avg), 32'h002); // 0x00B >> 2

    // Settle timer: clear, then full exactly 32767 edges after the clear edge.
    @(posedge clk); #1;
    clr_tmr = 1'b1;
    @(posedge clk); #1;
    clr_tmr = 1'b0;
    check("tmr_after_clr", 32'(tmr_full), 32'd0);
    repeat (32766) @(posedge clk);
    #1;
    check("tmr_one_short", 32'(tmr_full), 32'd0);
    @(posedge clk); #1;
    check("tmr_full_rise", 32'(tmr_full), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("tmr_full_hold", 32'(tmr_full), 32'd1);
    // Clear concurrent with a sample: both paths act.
    clr_tmr = 1'b1;
    feed(1, 12'h3FF, 12'h3FF);
    clr_tmr = 1'b0;
    check("tmr_clr_again", 32'(tmr_full), 32'd0);

    // Mid-block reset: the partial block (including the sample above) is lost.
    feed(2, 12'h3FF, 12'h3FF);
    rst = 1'b1;
    #3;
    check("midrst_lft_avg", 32'(lft_avg), 32'd0);
    check("midrst_lt", 32'(sum_lt_min), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    block("post_rst", 12'h100, 12'h100, 12'h100, 12'h100, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_load_cell_cond
